// File: rtl/mole_round_scheduler.sv
// Round sequencer for the whac-a-mole game FSM: LFSR mole pick, rng_ready handshake,
// level-scaled hit window and round/game-over bookkeeping. Optional: MOLE_NO_REPEAT_EN.
module mole_round_scheduler #(
    parameter int          NUM_MOLES       = 8,
    parameter int          WINDOW_CYCLES   = 50_000_000,
    parameter int          CNT_W           = 26,
    parameter int          ROUNDS_PER_GAME = 30,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ready_for_mole,
    input  logic                         timeout_start,
    input  logic [1:0]                   level_select,
    input  logic                         clear_game,
    output logic                         rng_ready,
    output logic                         timeout,
    output logic [$clog2(NUM_MOLES)-1:0] mole_idx,
    output logic [NUM_MOLES-1:0]         mole_sel,
    output logic [7:0]                   rounds_done,
    output logic                         game_over
);

    localparam int               IDX_W     = $clog2(NUM_MOLES);
    localparam logic [15:0]      LFSR_MASK = 16'hB400;
    localparam logic [CNT_W-1:0] WIN_BASE  = CNT_W'(WINDOW_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_PICK, S_ARM, S_WIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [IDX_W-1:0] pick_q, pick_d;
    logic [IDX_W-1:0] mole_idx_q, mole_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             rng_ready_q, rng_ready_d;
    logic             sel_vld_q, sel_vld_d;
    logic [7:0]       rounds_q, rounds_d;
    logic             game_over_q, game_over_d;
`ifdef MOLE_NO_REPEAT_EN
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic             last_valid_q, last_valid_d;
`endif

    logic [CNT_W-1:0] win_shift, win, cnt_dec;
    logic [IDX_W-1:0] raw_idx, pick_idx;
    logic [7:0]       rounds_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lfsr_q       <= LFSR_SEED;
            pick_q       <= '0;
            mole_idx_q   <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            rng_ready_q  <= 1'b0;
            sel_vld_q    <= 1'b0;
            rounds_q     <= '0;
            game_over_q  <= 1'b0;
`ifdef MOLE_NO_REPEAT_EN
            last_idx_q   <= '0;
            last_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            pick_q       <= pick_d;
            mole_idx_q   <= mole_idx_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            rng_ready_q  <= rng_ready_d;
            sel_vld_q    <= sel_vld_d;
            rounds_q     <= rounds_d;
            game_over_q  <= game_over_d;
`ifdef MOLE_NO_REPEAT_EN
            last_idx_q   <= last_idx_d;
            last_valid_q <= last_valid_d;
`endif
        end
    end

    always_comb begin
        lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
        win_shift  = WIN_BASE >> level_select;
        win        = (win_shift == '0) ? CNT_W'(1) : win_shift;
        raw_idx    = IDX_W'(lfsr_q % 16'(NUM_MOLES));
        cnt_dec    = (cnt_q != '0) ? (cnt_q - 1'b1) : cnt_q;
        rounds_inc = (rounds_q == 8'hFF) ? rounds_q : (rounds_q + 8'd1);
`ifdef MOLE_NO_REPEAT_EN
        if (last_valid_q && (pick_q == last_idx_q)) begin
            pick_idx = (pick_q == IDX_W'(NUM_MOLES - 1)) ? '0 : (pick_q + 1'b1);
        end else begin
            pick_idx = pick_q;
        end
`else
        pick_idx   = pick_q;
`endif

        state_d      = state_q;
        pick_d       = pick_q;
        mole_idx_d   = mole_idx_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        rng_ready_d  = 1'b0;
        sel_vld_d    = sel_vld_q;
        rounds_d     = rounds_q;
        game_over_d  = game_over_q;
`ifdef MOLE_NO_REPEAT_EN
        last_idx_d   = last_idx_q;
        last_valid_d = last_valid_q;
`endif

        case (state_q)
            // Index sampled on the edge leaving IDLE, so a request straight out of reset uses the seed.
            S_IDLE: begin
                if (ready_for_mole) begin
                    pick_d  = raw_idx;
                    state_d = S_PICK;
                end
            end
            S_PICK: begin
                mole_idx_d   = pick_idx;
                cnt_d        = win;
                timeout_d    = 1'b1;
                rng_ready_d  = 1'b1;
                sel_vld_d    = 1'b1;
`ifdef MOLE_NO_REPEAT_EN
                last_idx_d   = pick_idx;
                last_valid_d = 1'b1;
`endif
                state_d      = S_ARM;
            end
            S_ARM: begin
                if (timeout_start) begin
                    state_d = S_WIN;
                end else if (!ready_for_mole) begin
                    timeout_d = 1'b0;
                    sel_vld_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_WIN: begin
                cnt_d     = cnt_dec;
                timeout_d = (cnt_dec != '0);
                if (!timeout_start) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                sel_vld_d = 1'b0;
                timeout_d = 1'b0;
                rounds_d  = rounds_inc;
                if (rounds_inc == 8'(ROUNDS_PER_GAME)) begin
                    game_over_d = 1'b1;
                end
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A clear in the same cycle as a round completion leaves the game fresh.
        if (clear_game) begin
            rounds_d    = '0;
            game_over_d = 1'b0;
        end
    end

    assign rng_ready   = rng_ready_q;
    assign timeout     = timeout_q;
    assign mole_idx    = mole_idx_q;
    assign mole_sel    = sel_vld_q ? (NUM_MOLES'(1) << mole_idx_q) : '0;
    assign rounds_done = rounds_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Self-checking bench for mole_round_scheduler: directed game rounds followed by randomized
// rounds, checked against a round-level reference model. Honours MOLE_NO_REPEAT_EN if defined.
module tb_mole_round_scheduler;

    localparam int N    = 4;
    localparam int WIN  = 16;
    localparam int WIN4 = 4;
    localparam int RPG  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ready_for_mole = 1'b0;
    logic       timeout_start = 1'b0;
    logic       clear_game = 1'b0;
    logic [1:0] level_select = 2'd0;

    logic       rng_ready, timeout, game_over;
    logic [1:0] mole_idx;
    logic [3:0] mole_sel;
    logic [7:0] rounds_done;
    logic       b_rng_ready, b_timeout, b_game_over;
    logic [1:0] b_mole_idx;
    logic [3:0] b_mole_sel;
    logic [7:0] b_rounds_done;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    int          m_rounds = 0;
    bit          m_go = 1'b0;
    bit          m_last_valid = 1'b0;
    int          m_last_idx = 0;

    mole_round_scheduler #(
        .NUM_MOLES(N), .WINDOW_CYCLES(WIN), .CNT_W(8), .ROUNDS_PER_GAME(RPG), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ready_for_mole(ready_for_mole), .timeout_start(timeout_start),
        .level_select(level_select), .clear_game(clear_game), .rng_ready(rng_ready),
        .timeout(timeout), .mole_idx(mole_idx), .mole_sel(mole_sel),
        .rounds_done(rounds_done), .game_over(game_over)
    );

    mole_round_scheduler #(
        .NUM_MOLES(N), .WINDOW_CYCLES(WIN4), .CNT_W(8), .ROUNDS_PER_GAME(RPG), .LFSR_SEED(16'hACE1)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .ready_for_mole(ready_for_mole), .timeout_start(timeout_start),
        .level_select(level_select), .clear_game(clear_game), .rng_ready(b_rng_ready),
        .timeout(b_timeout), .mole_idx(b_mole_idx), .mole_sel(b_mole_sel),
        .rounds_done(b_rounds_done), .game_over(b_game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic int win_of(input int base, input int lvl);
        int w;
        w = base >> lvl;
        return (w == 0) ? 1 : w;
    endfunction

    // Free-running LFSR reference, one step per clock out of reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rng"}, {31'd0, rng_ready}, 0);
        chk({tag, "_to"}, {31'd0, timeout}, 0);
        chk({tag, "_idx"}, {30'd0, mole_idx}, 0);
        chk({tag, "_sel"}, {28'd0, mole_sel}, 0);
        chk({tag, "_rounds"}, {24'd0, rounds_done}, 0);
        chk({tag, "_go"}, {31'd0, game_over}, 0);
        chk({tag, "_b_all"}, {b_rng_ready, b_timeout, b_mole_idx, b_mole_sel, b_rounds_done, b_game_over}, 0);
    endtask

    task automatic play_round(input int lvl, input int hold, input bit abort, input bit clr,
                              input bit rel_rst, input int new_lvl, output int got_idx);
        int exp_idx, w, w4;
        level_select   = 2'(lvl);
        ready_for_mole = 1'b1;
        if (rel_rst) rst_n = 1'b1;
        exp_idx = int'(m_lfsr % 16'(N));
`ifdef MOLE_NO_REPEAT_EN
        if (m_last_valid && exp_idx == m_last_idx) exp_idx = (exp_idx + 1) % N;
`endif
        w  = win_of(WIN, lvl);
        w4 = win_of(WIN4, lvl);
        tick();
        chk("rng_early", {31'd0, rng_ready}, 0);
        tick();
        chk("rng_pulse", {31'd0, rng_ready}, 1);
        chk("to_at_rng", {31'd0, timeout}, 1);
        chk("b_to_at_rng", {31'd0, b_timeout}, 1);
        chk("mole_idx", {30'd0, mole_idx}, exp_idx);
        chk("mole_sel", {28'd0, mole_sel}, 32'd1 << exp_idx);
        m_last_valid = 1'b1;
        m_last_idx   = exp_idx;
        got_idx      = int'(mole_idx);
        level_select = 2'(new_lvl);
        if (abort) begin
            ready_for_mole = 1'b0;
            timeout_start  = 1'b0;
            tick();
            chk("abort_to", {31'd0, timeout}, 0);
            chk("abort_sel", {28'd0, mole_sel}, 0);
            chk("abort_rounds", {24'd0, rounds_done}, m_rounds);
            return;
        end
        ready_for_mole = 1'b0;
        timeout_start  = 1'b1;
        tick();
        chk("rng_once", {31'd0, rng_ready}, 0);
        chk("to_win_entry", {31'd0, timeout}, 1);
        chk("b_to_win_entry", {31'd0, b_timeout}, 1);
        for (int h = 1; h <= hold; h++) begin
            tick();
            chk("to_win", {31'd0, timeout}, (w > h) ? 1 : 0);
            chk("b_to_win", {31'd0, b_timeout}, (w4 > h) ? 1 : 0);
            chk("sel_win", {28'd0, mole_sel}, 32'd1 << exp_idx);
        end
        timeout_start = 1'b0;
        tick();
        clear_game = clr;
        tick();
        clear_game = 1'b0;
        if (clr) begin
            m_rounds = 0;
            m_go     = 1'b0;
        end else begin
            m_rounds = (m_rounds < 255) ? m_rounds + 1 : 255;
            if (m_rounds == RPG) m_go = 1'b1;
        end
        chk("done_sel", {28'd0, mole_sel}, 0);
        chk("done_to", {31'd0, timeout}, 0);
        chk("done_b_to", {31'd0, b_timeout}, 0);
        chk("rounds_done", {24'd0, rounds_done}, m_rounds);
        chk("game_over", {31'd0, game_over}, {31'd0, m_go});
    endtask

    initial begin
        int idx, gap, lvl, hold, w;
        bit found;
        repeat (3) tick();
        chk_all_zero("reset");

        // Hit at level 0, straight out of reset so the seed picks mole 1.
        play_round(0, 5, 1'b0, 1'b0, 1'b1, 0, idx);
        chk("seed_idx", idx, 1);

        // Reset asserted in the middle of a window.
        ready_for_mole = 1'b1;
        tick();
        tick();
        ready_for_mole = 1'b0;
        timeout_start  = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset_mid_win");
        m_rounds = 0;
        m_go = 1'b0;
        m_last_valid = 1'b0;
        timeout_start = 1'b0;
        tick();
        tick();

        // Miss at level 2 (window 4), first pick again from the seed.
        play_round(2, 6, 1'b0, 1'b0, 1'b1, 2, idx);
        chk("seed_idx_2", idx, 1);
        // Level 3: second instance clamps its window to 1.
        play_round(3, 3, 1'b0, 1'b0, 1'b0, 0, idx);
        // Third round ends the game.
        play_round(1, 2, 1'b0, 1'b0, 1'b0, 3, idx);
        chk("go_after_3", {31'd0, game_over}, 1);
        // Clear in the completing round's DONE cycle.
        play_round(0, 1, 1'b0, 1'b1, 1'b0, 0, idx);
        chk("cleared_rounds", {24'd0, rounds_done}, 0);

        // Line up the LFSR so the raw index repeats the previous mole.
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (int'(m_lfsr % 16'(N)) == m_last_idx) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (found) begin
            int prev;
            prev = m_last_idx;
            play_round(1, 2, 1'b0, 1'b0, 1'b0, 1, idx);
`ifdef MOLE_NO_REPEAT_EN
            chk("no_repeat", idx, (prev + 1) % N);
`else
            chk("repeat_allowed", idx, prev);
`endif
        end

        for (int r = 0; r < 40; r++) begin
            gap = $urandom_range(0, 4);
            repeat (gap) tick();
            lvl  = $urandom_range(0, 3);
            w    = win_of(WIN, lvl);
            hold = $urandom_range(0, w + 2);
            play_round(lvl, hold, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                       1'b0, $urandom_range(0, 3), idx);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
